mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising clk edge.
REQ-003 ir_m  in  32  instruction in MEM stage; opcode = ir_m[31:26].
REQ-004 alu_out_m  in  32  effective byte address from EX/MEM.
REQ-005 rt_m  in  32  store data from EX/MEM.
REQ-006 mem_req  out  1  bus request, registered.
REQ-007 mem_we  out  1  1 = write, valid while mem_req.
REQ-008 mem_addr  out  32  word address, {alu_out_m[31:2],2'b00}, registered.
REQ-009 mem_be  out  4  byte enables, bit k = byte lane k (little-endian).
REQ-010 mem_wdata  out  32  lane-replicated store data.
REQ-011 mem_ack  in  1  one-cycle completion from memory; rdata valid same cycle.
REQ-012 mem_rdata  in  32  read word.
REQ-013 stall  out  1  combinational; freezes IF/ID/EX and EX/MEM register.
REQ-014 load_data  out  32  extended load result, registered.
REQ-015 load_valid  out  1  one-cycle pulse, load_data valid.
REQ-016 addr_err  out  1  one-cycle pulse, misaligned access, no bus cycle.

Function
REQ-017 Memory ops: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25, sb 0x28, sh 0x29, sw 0x2B; all other opcodes are non-memory and pass with no bus activity and stall=0.
REQ-018 Aligned: word needs addr[1:0]=00, half needs addr[0]=0, byte always.
REQ-019 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-020 IDLE: aligned memory op -> stall=1, latch addr/be/wdata/we/opcode/addr[1:0], next REQ; misaligned memory op -> addr_err=1 next cycle, stall=0, stay IDLE; otherwise stay IDLE.
REQ-021 REQ: mem_req=1, outputs held stable; stall=1; mem_ack=0 -> stay REQ (unbounded wait); mem_ack=1 -> capture and extend mem_rdata into load_data (loads only), next DONE.
REQ-022 DONE: mem_req=0, stall=0, load_valid=1 for loads only, next IDLE unconditionally.
REQ-023 Minimum latency memory op: 3 cycles from op arriving in ir_m to stall release (IDLE, REQ with ack, DONE); each extra non-ack REQ cycle adds 1.
REQ-024 stall = (state==IDLE && aligned memory op) || state==REQ.
REQ-025 Store encoding: sb be=1<<addr[1:0], wdata={4{rt[7:0]}}; sh be=0011 (addr[1]=0) or 1100, wdata={2{rt[15:0]}}; sw be=1111, wdata=rt.
REQ-026 Load encoding: be as for store of same size; lane selected by latched addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw unmodified.
REQ-027 mem_ack in IDLE or DONE is ignored.
REQ-028 load_data holds its value until next load completion; stores do not alter it.
REQ-029 Back-to-back memory ops: DONE -> IDLE, next op detected in IDLE cycle; no op skipped or duplicated.

Reset
REQ-030 reset=1 at clk edge: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, load_data 0, load_valid 0, addr_err 0.
REQ-031 Reset during REQ drops mem_req next cycle; a same-cycle mem_ack is discarded, load_valid stays 0.
REQ-032 Reset has priority over mem_ack and all state transitions.

Verification
REQ-033 lw, alu_out_m=0x100, ack in first REQ cycle, rdata=0xDEADBEEF -> mem_addr 0x100, be 1111, stall 2 cycles, load_data 0xDEADBEEF, load_valid 1 pulse.
REQ-034 lb, addr 0x103, rdata=0x80123456 -> be 1000, load_data 0xFFFFFF80; lbu same -> 0x00000080.
REQ-035 sh, addr 0x202, rt=0x0000ABCD -> mem_we 1, be 1100, wdata 0xABCDABCD, load_valid 0.
REQ-036 lw, addr 0x101 -> addr_err 1 pulse, mem_req never asserted, stall 0.
REQ-037 sw with ack delayed 4 cycles -> mem_req, addr, be, wdata stable 5 cycles; stall 6 cycles total.
REQ-038 lh in REQ, reset asserted with mem_ack -> all outputs 0 next cycle, no load_valid.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit for the MEM stage: decodes loads/stores, runs a
// request/ack bus handshake, stalls the front of the pipe while the access is
// in flight and returns sign/zero-extended load data.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ir_m,
  input  logic [31:0] alu_out_m,
  input  logic [31:0] rt_m,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        addr_err
);

  localparam int unsigned OPW = 6;
  localparam int unsigned BEW = 4;

  localparam logic [OPW-1:0] OP_LB  = 6'h20;
  localparam logic [OPW-1:0] OP_LH  = 6'h21;
  localparam logic [OPW-1:0] OP_LW  = 6'h23;
  localparam logic [OPW-1:0] OP_LBU = 6'h24;
  localparam logic [OPW-1:0] OP_LHU = 6'h25;
  localparam logic [OPW-1:0] OP_SB  = 6'h28;
  localparam logic [OPW-1:0] OP_SH  = 6'h29;
  localparam logic [OPW-1:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [OPW-1:0] opcode;
  logic           is_mem;
  logic           is_store;
  logic           aligned;
  logic [BEW-1:0] be_c;
  logic [31:0]    wdata_c;

  logic           latch_c;
  logic           err_c;
  logic           ack_c;

  logic [OPW-1:0] op_q;
  logic [1:0]     off_q;
  logic [7:0]     lane_b;
  logic [15:0]    lane_h;
  logic [31:0]    ext_c;

  logic           unused_ir_bits;

  assign opcode         = ir_m[31:26];
  assign unused_ir_bits = ^ir_m[25:0];

  // Decode opcode into size, direction, alignment, byte enables and lane data
  always_comb begin
    is_mem   = 1'b0;
    is_store = 1'b0;
    aligned  = 1'b1;
    be_c     = '0;
    wdata_c  = rt_m;
    case (opcode)
      OP_LB, OP_LBU, OP_SB: begin
        is_mem   = 1'b1;
        is_store = (opcode == OP_SB);
        be_c     = 4'b0001 << alu_out_m[1:0];
        wdata_c  = {4{rt_m[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        is_mem   = 1'b1;
        is_store = (opcode == OP_SH);
        aligned  = ~alu_out_m[0];
        be_c     = alu_out_m[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{rt_m[15:0]}};
      end
      OP_LW, OP_SW: begin
        is_mem   = 1'b1;
        is_store = (opcode == OP_SW);
        aligned  = (alu_out_m[1:0] == 2'b00);
        be_c     = 4'b1111;
        wdata_c  = rt_m;
      end
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; REQ waits on mem_ack without a timeout
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (is_mem && aligned) state_next = S_REQ;
      S_REQ:   if (mem_ack)           state_next = S_DONE;
      S_DONE:                         state_next = S_IDLE;
      default:                        state_next = S_IDLE;
    endcase
  end

  // Per-state controls: stall is combinational, the rest feed registers
  always_comb begin
    stall   = 1'b0;
    latch_c = 1'b0;
    err_c   = 1'b0;
    ack_c   = 1'b0;
    case (state)
      S_IDLE: begin
        stall   = is_mem && aligned;
        latch_c = is_mem && aligned;
        err_c   = is_mem && !aligned;
      end
      S_REQ: begin
        stall = 1'b1;
        ack_c = mem_ack;
      end
      default: ;
    endcase
  end

  // Select the addressed lane of the returned word and extend it
  always_comb begin
    lane_b = 8'(mem_rdata >> {off_q, 3'b000});
    lane_h = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (op_q)
      OP_LB:   ext_c = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ext_c = {24'h000000, lane_b};
      OP_LH:   ext_c = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ext_c = {16'h0000, lane_h};
      default: ext_c = mem_rdata;
    endcase
  end

  // Registered bus outputs, latched access info and load result
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      load_data  <= '0;
      load_valid <= 1'b0;
      addr_err   <= 1'b0;
      op_q       <= '0;
      off_q      <= '0;
    end else begin
      mem_req    <= (state_next == S_REQ);
      addr_err   <= err_c;
      load_valid <= ack_c && !mem_we;
      if (latch_c) begin
        mem_we    <= is_store;
        mem_addr  <= {alu_out_m[31:2], 2'b00};
        mem_be    <= be_c;
        mem_wdata <= wdata_c;
        op_q      <= opcode;
        off_q     <= alu_out_m[1:0];
      end
      if (ack_c && !mem_we) load_data <= ext_c;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vector table, reset and
// handshake corner sequences, and randomized ops against a reference model.
module tb_mem_access_unit;

  localparam logic [5:0] LB  = 6'h20;
  localparam logic [5:0] LH  = 6'h21;
  localparam logic [5:0] LW  = 6'h23;
  localparam logic [5:0] LBU = 6'h24;
  localparam logic [5:0] LHU = 6'h25;
  localparam logic [5:0] SB  = 6'h28;
  localparam logic [5:0] SH  = 6'h29;
  localparam logic [5:0] SW  = 6'h2B;
  localparam logic [5:0] NOP = 6'h00;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ir_m;
  logic [31:0] alu_out_m;
  logic [31:0] rt_m;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        addr_err;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk        (clk),
    .reset      (reset),
    .ir_m       (ir_m),
    .alu_out_m  (alu_out_m),
    .rt_m       (rt_m),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .load_data  (load_data),
    .load_valid (load_valid),
    .addr_err   (addr_err)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] model_ld    = 32'h0;

  typedef struct {
    int          stall_n;
    int          req_n;
    int          err_n;
    int          lv_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] ld;
  } exp_t;

  typedef struct {
    int          stall_n;
    int          req_n;
    int          err_n;
    int          lv_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [31:0] ld;
    bit          stable;
    bit          timeout;
  } obs_t;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] rt;
    int          delay;
    logic [31:0] rdata;
    exp_t        e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Present one instruction, play the memory side, and record what the DUT did
  task automatic run_op(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input int delay, input logic [31:0] rdata, input bit tail,
                        output obs_t o);
    int cyc;
    bit done;
    o = '{default: 0};
    o.stable = 1'b1;
    cyc = 0;
    done = 1'b0;
    @(negedge clk);
    ir_m      = {op, 26'($urandom)};
    alu_out_m = addr;
    rt_m      = rt;
    mem_ack   = 1'b0;
    while (!done) begin
      #1;
      if (stall)      o.stall_n++;
      if (addr_err)   o.err_n++;
      if (load_valid) o.lv_n++;
      if (mem_req) begin
        if (o.req_n == 0) begin
          o.addr  = mem_addr;
          o.be    = mem_be;
          o.we    = mem_we;
          o.wdata = mem_wdata;
        end else if (mem_addr !== o.addr || mem_be !== o.be ||
                     mem_we !== o.we || mem_wdata !== o.wdata) begin
          o.stable = 1'b0;
        end
        o.req_n++;
      end
      o.ld = load_data;
      if (mem_req && o.req_n == delay + 1) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
      if (!stall) done = 1'b1;
      cyc++;
      if (cyc > 40) begin
        o.timeout = 1'b1;
        done = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    if (tail) begin
      @(negedge clk);
      ir_m    = {NOP, 26'h0};
      mem_ack = 1'b0;
      #1;
      if (addr_err)   o.err_n++;
      if (load_valid) o.lv_n++;
    end
  endtask

  task automatic verify(input string tag, input obs_t o, input exp_t e);
    check({tag, "/timeout"}, 32'(o.timeout), 32'h0);
    check({tag, "/stall_cycles"}, 32'(o.stall_n), 32'(e.stall_n));
    check({tag, "/req_cycles"}, 32'(o.req_n), 32'(e.req_n));
    check({tag, "/addr_err"}, 32'(o.err_n), 32'(e.err_n));
    check({tag, "/load_valid"}, 32'(o.lv_n), 32'(e.lv_n));
    check({tag, "/load_data"}, o.ld, e.ld);
    if (e.req_n > 0) begin
      check({tag, "/mem_addr"}, o.addr, e.addr);
      check({tag, "/mem_be"}, 32'(o.be), 32'(e.be));
      check({tag, "/mem_we"}, 32'(o.we), 32'(e.we));
      check({tag, "/req_stable"}, 32'(o.stable), 32'h1);
      if (e.we) check({tag, "/mem_wdata"}, o.wdata, e.wdata);
    end
  endtask

  // Reference behaviour from access size and byte offset arithmetic
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rt,
                                 input int delay, input logic [31:0] rd, input bit tail,
                                 input logic [31:0] prev_ld);
    exp_t        e;
    int          size;
    int          off;
    bit          load;
    logic [31:0] raw;
    logic [31:0] mask;
    e = '{default: 0};
    e.ld = prev_ld;
    case (op)
      LB, LBU, SB: size = 1;
      LH, LHU, SH: size = 2;
      LW, SW:      size = 4;
      default:     size = 0;
    endcase
    if (size == 0) return e;
    load = (op == LB || op == LH || op == LW || op == LBU || op == LHU);
    if ((a % 32'(size)) != 0) begin
      e.err_n = tail ? 1 : 0;
      return e;
    end
    off       = int'(a % 4);
    e.stall_n = delay + 2;
    e.req_n   = delay + 1;
    e.lv_n    = load ? 1 : 0;
    e.addr    = a - 32'(off);
    e.be      = 4'(((1 << size) - 1) << off);
    e.we      = !load;
    e.wdata   = (size == 1) ? 32'(rt[7:0]) * 32'h01010101 :
                (size == 2) ? 32'(rt[15:0]) * 32'h00010001 : rt;
    if (load) begin
      mask = (size == 4) ? 32'hFFFFFFFF : (32'h1 << (8 * size)) - 32'h1;
      raw  = (rd >> (8 * off)) & mask;
      if (op == LB && raw[7])  raw = raw | 32'hFFFFFF00;
      if (op == LH && raw[15]) raw = raw | 32'hFFFF0000;
      e.ld = raw;
    end
    return e;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        tbl[12];
    obs_t        o;
    exp_t        e;
    logic [5:0]  ops[9];
    logic [5:0]  op;
    logic [31:0] a;
    bit          tail;

    tbl[0]  = '{LW,  32'h100, 32'h0,        0, 32'hDEADBEEF, '{2, 1, 0, 1, 32'h100, 32'h0,        4'hF, 1'b0, 32'hDEADBEEF}};
    tbl[1]  = '{LB,  32'h103, 32'h0,        0, 32'h80123456, '{2, 1, 0, 1, 32'h100, 32'h0,        4'h8, 1'b0, 32'hFFFFFF80}};
    tbl[2]  = '{LBU, 32'h103, 32'h0,        0, 32'h80123456, '{2, 1, 0, 1, 32'h100, 32'h0,        4'h8, 1'b0, 32'h00000080}};
    tbl[3]  = '{SH,  32'h202, 32'h0000ABCD, 0, 32'h0,        '{2, 1, 0, 0, 32'h200, 32'hABCDABCD, 4'hC, 1'b1, 32'h00000080}};
    tbl[4]  = '{LW,  32'h101, 32'h0,        0, 32'h0,        '{0, 0, 1, 0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h00000080}};
    tbl[5]  = '{SW,  32'h300, 32'h12345678, 4, 32'h0,        '{6, 5, 0, 0, 32'h300, 32'h12345678, 4'hF, 1'b1, 32'h00000080}};
    tbl[6]  = '{LH,  32'h102, 32'h0,        0, 32'h80017FFF, '{2, 1, 0, 1, 32'h100, 32'h0,        4'hC, 1'b0, 32'hFFFF8001}};
    tbl[7]  = '{LHU, 32'h100, 32'h0,        1, 32'h8001F00F, '{3, 2, 0, 1, 32'h100, 32'h0,        4'h3, 1'b0, 32'h0000F00F}};
    tbl[8]  = '{SB,  32'h101, 32'h000000A5, 0, 32'h0,        '{2, 1, 0, 0, 32'h100, 32'hA5A5A5A5, 4'h2, 1'b1, 32'h0000F00F}};
    tbl[9]  = '{SH,  32'h201, 32'h0,        0, 32'h0,        '{0, 0, 1, 0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0000F00F}};
    tbl[10] = '{NOP, 32'h100, 32'h0,        0, 32'h0,        '{0, 0, 0, 0, 32'h0,   32'h0,        4'h0, 1'b0, 32'h0000F00F}};
    tbl[11] = '{LB,  32'h101, 32'h0,        2, 32'h00007F00, '{4, 3, 0, 1, 32'h100, 32'h0,        4'h2, 1'b0, 32'h0000007F}};

    ops = '{LB, LH, LW, LBU, LHU, SB, SH, SW, NOP};

    // Reset state
    reset     = 1'b1;
    ir_m      = 32'h0;
    alu_out_m = 32'h0;
    rt_m      = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset/mem_req",    32'(mem_req), 32'h0);
    check("reset/mem_we",     32'(mem_we), 32'h0);
    check("reset/mem_addr",   mem_addr, 32'h0);
    check("reset/mem_be",     32'(mem_be), 32'h0);
    check("reset/mem_wdata",  mem_wdata, 32'h0);
    check("reset/load_data",  load_data, 32'h0);
    check("reset/load_valid", 32'(load_valid), 32'h0);
    check("reset/addr_err",   32'(addr_err), 32'h0);
    check("reset/stall",      32'(stall), 32'h0);
    reset = 1'b0;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].addr, tbl[i].rt, tbl[i].delay, tbl[i].rdata, 1'b1, o);
      verify($sformatf("vec%0d", i), o, tbl[i].e);
    end
    model_ld = 32'h0000007F;

    // mem_ack while idle must not start or complete anything
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ir_m      = {NOP, 26'h0};
      mem_ack   = 1'b1;
      mem_rdata = 32'hFFFFFFFF;
      #1;
      check("idle_ack/mem_req",    32'(mem_req), 32'h0);
      check("idle_ack/load_valid", 32'(load_valid), 32'h0);
      check("idle_ack/load_data",  load_data, model_ld);
    end
    @(negedge clk);
    mem_ack = 1'b0;

    // Reset during REQ coinciding with mem_ack
    ir_m      = {LH, 26'h0};
    alu_out_m = 32'h102;
    #1;
    check("rst_req/stall_idle", 32'(stall), 32'h1);
    @(negedge clk);
    #1;
    check("rst_req/mem_req", 32'(mem_req), 32'h1);
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h80018001;
    @(negedge clk);
    reset   = 1'b0;
    mem_ack = 1'b0;
    ir_m    = {NOP, 26'h0};
    #1;
    check("rst_req/mem_req_after",  32'(mem_req), 32'h0);
    check("rst_req/mem_we",         32'(mem_we), 32'h0);
    check("rst_req/mem_addr",       mem_addr, 32'h0);
    check("rst_req/mem_be",         32'(mem_be), 32'h0);
    check("rst_req/mem_wdata",      mem_wdata, 32'h0);
    check("rst_req/load_data",      load_data, 32'h0);
    check("rst_req/load_valid",     32'(load_valid), 32'h0);
    check("rst_req/addr_err",       32'(addr_err), 32'h0);
    check("rst_req/stall",          32'(stall), 32'h0);
    @(negedge clk);
    #1;
    check("rst_req/load_valid_late", 32'(load_valid), 32'h0);
    check("rst_req/mem_req_late",    32'(mem_req), 32'h0);
    model_ld = 32'h0;

    // Randomized ops, back-to-back where aligned
    for (int i = 0; i < 200; i++) begin
      logic [31:0] rt;
      logic [31:0] rd;
      int          dly;
      op   = ops[$urandom_range(0, 8)];
      if (op == NOP) op = 6'($urandom_range(0, 31));
      a    = 32'h1000 + 32'($urandom_range(0, 255));
      rt   = $urandom;
      rd   = $urandom;
      dly  = $urandom_range(0, 3);
      e    = model(op, a, rt, dly, rd, 1'b1, model_ld);
      tail = (e.err_n != 0) || ($urandom_range(0, 1) == 1);
      e    = model(op, a, rt, dly, rd, tail, model_ld);
      run_op(op, a, rt, dly, rd, tail, o);
      verify($sformatf("rnd%0d_op%02h", i, op), o, e);
      model_ld = e.ld;
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
